// File: rtl/fc_param_writer.sv
// fc_param_writer: read-modify-write pan/zoom/home updates of the fractcore view words
module fc_param_writer #(
  parameter int          PAN_SHIFT  = 4,
  parameter int          ZOOM_SHIFT = 3,
  parameter logic [31:0] ZOOM_MIN   = 32'h0000_0100,
  parameter logic [31:0] ZOOM_MAX   = 32'h4000_0000,
  parameter logic [31:0] HOME_X     = 32'hFE00_0000,
  parameter logic [31:0] HOME_Y     = 32'h0000_0000,
  parameter logic [31:0] HOME_ZOOM  = 32'h0400_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  input  logic [2:0]  cmd_op,
  output logic        cmd_ready,
  output logic        done,
  output logic        f_memwrite,
  output logic [12:0] addr,
  output logic [31:0] writedata,
  input  logic [31:0] readdata
);
  typedef enum logic [2:0] {IDLE, RD_ZOOM, RD_TGT, WR, WR_H0, WR_H1, WR_H2, DONE} state_t;
  localparam logic signed [33:0] P_MAX = 34'sd2147483647;
  localparam logic signed [33:0] P_MIN = -34'sd2147483648;
  state_t state_q, state_d;
  logic [2:0] op_q, op_d;
  logic [31:0] zoom_q, zoom_d, tgt_q, tgt_d;
  logic [31:0] sh_p, step, sh_z, dz, zin, zout, pan_sat, result;
  logic [32:0] zsum;
  logic signed [33:0] pan_s;
  logic [4:0] tgt_addr, a5;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= '0;
      zoom_q  <= '0;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      zoom_q  <= zoom_d;
      tgt_q   <= tgt_d;
    end
  end
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    zoom_d  = zoom_q;
    tgt_d   = tgt_q;
    unique case (state_q)
      IDLE: if (cmd_valid) begin
        op_d    = cmd_op;
        state_d = cmd_op == 3'd6 ? WR_H0 : cmd_op == 3'd7 ? DONE : RD_ZOOM;
      end
      RD_ZOOM: begin
        zoom_d  = readdata;
        state_d = RD_TGT;
      end
      RD_TGT: begin
        tgt_d   = readdata;
        state_d = WR;
      end
      WR:      state_d = DONE;
      WR_H0:   state_d = WR_H1;
      WR_H1:   state_d = WR_H2;
      WR_H2:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    sh_p     = zoom_q >> PAN_SHIFT;
    step     = sh_p == '0 ? 32'd1 : sh_p;
    sh_z     = zoom_q >> ZOOM_SHIFT;
    dz       = sh_z == '0 ? 32'd1 : sh_z;
    pan_s    = op_q[0] ? $signed({{2{tgt_q[31]}}, tgt_q}) + $signed({2'b00, step})
                       : $signed({{2{tgt_q[31]}}, tgt_q}) - $signed({2'b00, step});
    pan_sat  = pan_s > P_MAX ? 32'h7FFF_FFFF : pan_s < P_MIN ? 32'h8000_0000 : pan_s[31:0];
    zin      = (zoom_q < dz || (zoom_q - dz) < ZOOM_MIN) ? ZOOM_MIN : zoom_q - dz;
    zsum     = {1'b0, zoom_q} + {1'b0, dz};
    zout     = (zsum[32] || zsum[31:0] > ZOOM_MAX) ? ZOOM_MAX : zsum[31:0];
    result   = op_q[2] ? (op_q[0] ? zout : zin) : pan_sat;
    tgt_addr = op_q[2:1] == 2'd0 ? 5'h1F : op_q[2:1] == 2'd1 ? 5'h1E : 5'h1D;
    a5       = state_q == RD_ZOOM ? 5'h1D :
               (state_q == RD_TGT || state_q == WR) ? tgt_addr :
               state_q == WR_H0 ? 5'h1F :
               state_q == WR_H1 ? 5'h1E :
               state_q == WR_H2 ? 5'h1D : 5'h00;
    addr       = {8'd0, a5};
    writedata  = state_q == WR    ? result :
                 state_q == WR_H0 ? HOME_X :
                 state_q == WR_H1 ? HOME_Y :
                 state_q == WR_H2 ? HOME_ZOOM : 32'd0;
    f_memwrite = state_q == WR || state_q == WR_H0 || state_q == WR_H1 || state_q == WR_H2;
    cmd_ready  = state_q == IDLE;
    done       = state_q == DONE;
  end
endmodule

// File: tb/tb_fc_param_writer.sv
// tb_fc_param_writer: directed self-checking bench for fc_param_writer
module tb_fc_param_writer;
  logic        clk = 0;
  logic        reset = 1;
  logic        cmd_valid = 0;
  logic [2:0]  cmd_op = 0;
  logic        cmd_ready, done, f_memwrite;
  logic [12:0] addr;
  logic [31:0] writedata, readdata;
  logic [31:0] mem [0:31];
  logic        pre_we = 0;
  logic [4:0]  pre_a = 0;
  logic [31:0] pre_d = 0;
  logic        bus_bad = 0;
  int          wr_cnt = 0;
  int          checks = 0;
  int          errors = 0;
  fc_param_writer dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
    .cmd_ready(cmd_ready), .done(done), .f_memwrite(f_memwrite),
    .addr(addr), .writedata(writedata), .readdata(readdata)
  );
  always #5 clk = ~clk;
  assign readdata = mem[addr[4:0]];
  always @(posedge clk) begin
    if (f_memwrite) begin
      mem[addr[4:0]] <= writedata;
      wr_cnt <= wr_cnt + 1;
    end
    if (pre_we) mem[pre_a] <= pre_d;
  end
  always @(negedge clk)
    if (addr[12:5] != 0 || (!f_memwrite && writedata != 0)) bus_bad <= 1;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic preload(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    pre_we = 1; pre_a = a; pre_d = d;
    @(negedge clk);
    pre_we = 0;
  endtask
  task automatic run(input string tag, input logic [2:0] op, input int exp_lat, input int exp_wr);
    int k, w0;
    @(negedge clk);
    check({tag, "_ready"}, {31'd0, cmd_ready}, 1);
    cmd_valid = 1; cmd_op = op; w0 = wr_cnt;
    k = 0;
    do begin
      @(negedge clk);
      cmd_valid = 0;
      k++;
    end while (!done && k < 12);
    check({tag, "_lat"}, k, exp_lat);
    check({tag, "_nwr"}, wr_cnt - w0, exp_wr);
    @(negedge clk);
    check({tag, "_ready_after"}, {31'd0, cmd_ready}, 1);
  endtask
  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 0;
    repeat (3) @(negedge clk);
    reset = 0;
    check("rst_ready", {31'd0, cmd_ready}, 1);
    check("rst_done", {31'd0, done}, 0);
    check("rst_we", {31'd0, f_memwrite}, 0);
    check("rst_addr", {19'd0, addr}, 0);
    check("rst_wdata", writedata, 0);
    preload(5'h1D, 32'h0400_0000);
    preload(5'h1F, 32'h0000_0000);
    run("right", 3'd1, 4, 1);
    check("right_x", mem[5'h1F], 32'h0040_0000);
    run("zin", 3'd4, 4, 1);
    check("zin_z", mem[5'h1D], 32'h0380_0000);
    run("zout", 3'd5, 4, 1);
    check("zout_z", mem[5'h1D], 32'h03F0_0000);
    preload(5'h1D, 32'h0400_0000);
    preload(5'h1F, 32'h7FFF_FFF0);
    run("sat_hi", 3'd1, 4, 1);
    check("sat_hi_x", mem[5'h1F], 32'h7FFF_FFFF);
    preload(5'h1E, 32'h8000_0010);
    run("sat_lo", 3'd2, 4, 1);
    check("sat_lo_y", mem[5'h1E], 32'h8000_0000);
    preload(5'h1D, 32'h0000_0104);
    run("zmin", 3'd4, 4, 1);
    check("zmin_z", mem[5'h1D], 32'h0000_0100);
    preload(5'h1D, 32'h3C00_0000);
    run("zmax", 3'd5, 4, 1);
    check("zmax_z", mem[5'h1D], 32'h4000_0000);
    preload(5'h1E, 32'h0000_0000);
    run("down", 3'd3, 4, 1);
    check("down_y", mem[5'h1E], 32'h0400_0000);
    @(negedge clk);
    cmd_valid = 1; cmd_op = 3'd6;
    @(negedge clk);
    cmd_op = 3'd0;
    check("h0_we", {31'd0, f_memwrite}, 1);
    check("h0_addr", {19'd0, addr}, 32'h1F);
    check("h0_data", writedata, 32'hFE00_0000);
    @(negedge clk);
    check("h1_addr", {19'd0, addr}, 32'h1E);
    check("h1_data", writedata, 32'h0000_0000);
    @(negedge clk);
    check("h2_addr", {19'd0, addr}, 32'h1D);
    check("h2_data", writedata, 32'h0400_0000);
    @(negedge clk);
    check("h_done", {31'd0, done}, 1);
    check("h_busy", {31'd0, cmd_ready}, 0);
    @(negedge clk);
    check("h_idle", {31'd0, cmd_ready}, 1);
    @(negedge clk);
    cmd_valid = 0;
    check("h_next_rd", {19'd0, addr}, 32'h1D);
    check("h_next_busy", {31'd0, cmd_ready}, 0);
    begin
      int k = 0;
      while (!done && k < 12) begin
        @(negedge clk);
        k++;
      end
      check("h_next_lat", k, 3);
    end
    check("home_x", mem[5'h1F], 32'hFDC0_0000);
    check("home_y", mem[5'h1E], 32'h0000_0000);
    check("home_z", mem[5'h1D], 32'h0400_0000);
    preload(5'h1F, 32'h0000_1234);
    begin
      int w0;
      @(negedge clk);
      w0 = wr_cnt;
      cmd_valid = 1; cmd_op = 3'd1;
      @(negedge clk);
      cmd_valid = 0;
      @(negedge clk);
      reset = 1;
      @(negedge clk);
      reset = 0;
      check("rst_mid_ready", {31'd0, cmd_ready}, 1);
      check("rst_mid_we", {31'd0, f_memwrite}, 0);
      repeat (4) @(negedge clk);
      check("rst_mid_nwr", wr_cnt - w0, 0);
      check("rst_mid_x", mem[5'h1F], 32'h0000_1234);
    end
    run("nop", 3'd7, 1, 0);
    check("bus_idle", {31'd0, bus_bad}, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
